// File: rtl/point_fetch_pkg.sv
// point_fetch_pkg: shared definitions for the point_fetch engine.
//   - shared-memory addresses of the host and client status words
//   - bit positions inside the host status word and inside a point word
//   - FSM state encoding
//   - helpers that build the client acknowledge word and point addresses
package point_fetch_pkg;

  localparam logic [31:0] HOST_STAT_ADDR   = 32'h0000_0400;
  localparam logic [31:0] CLIENT_STAT_ADDR = 32'h0000_0404;

  // Host status word fields
  localparam int GO_BIT = 31;
  localparam int ID_MSB = 15;
  localparam int ID_LSB = 8;
  localparam int N_MSB  = 7;
  localparam int N_LSB  = 0;

  // Point word fields; bits [31:25] carry no meaning
  localparam int X_MSB     = 11;
  localparam int X_LSB     = 0;
  localparam int Y_MSB     = 23;
  localparam int Y_LSB     = 12;
  localparam int LASER_BIT = 24;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POLL,
    S_POLL_WAIT,
    S_FETCH,
    S_FETCH_WAIT,
    S_OUT,
    S_ACK
  } state_e;

  // Client status word: done flag in [31], echoed id and count below.
  function automatic logic [31:0] ack_word(input logic [7:0] id, input logic [7:0] n);
    return {1'b1, 15'b0, id, n};
  endfunction

  // Byte address of point word idx (word index lives in [9:2]).
  function automatic logic [31:0] point_addr(input logic [7:0] idx);
    return {22'b0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/point_fetch_poll_timer.sv
// point_fetch_poll_timer: idle-period counter between host status polls.
//   clk_i      in   clock
//   rst_ni     in   synchronous active-low reset
//   en_i       in   count while high (engine idle); counter clears when low
//   expired_o  out  high on the last of POLL_CYCLES enabled cycles
module point_fetch_poll_timer #(
  parameter int POLL_CYCLES = 1000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic expired_o
);

  localparam int               CW   = $clog2(POLL_CYCLES + 1);
  localparam logic [CW-1:0]    TERM = CW'(POLL_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = en_i && (cnt_q == TERM);

  // Clearing whenever the engine leaves IDLE gives every idle stretch its
  // full length, independent of where the previous one was cut short.
  always_comb begin
    cnt_d = '0;
    if (en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/point_fetch.sv
// point_fetch: polls the host status word, fetches the host point list from
// shared RAM and streams it as (x, y, laser) points; acknowledges each newly
// completed frame id once in the client status word.
//   clk, reset_n            clock, synchronous active-low reset
//   mem_addr/mem_din        shared-memory read port (data one cycle after addr)
//   mem_dout/mem_we         client status write (only at 0x404)
//   pt_valid/pt_ready       point handshake; pt_x, pt_y, pt_laser, pt_last payload
//   busy                    high whenever the engine is not idle
//   frame_count             completed list renders (wraps)
module point_fetch
  import point_fetch_pkg::*;
#(
  parameter int POLL_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_din,
  output logic [31:0] mem_dout,
  output logic        mem_we,
  output logic        pt_valid,
  input  logic        pt_ready,
  output logic [11:0] pt_x,
  output logic [11:0] pt_y,
  output logic        pt_laser,
  output logic        pt_last,
  output logic        busy,
  output logic [15:0] frame_count
);

  state_e      state_q, state_d;
  logic [7:0]  id_q, id_d;
  logic [7:0]  n_q, n_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  acked_id_q, acked_id_d;
  logic        acked_valid_q, acked_valid_d;
  logic        pt_valid_q, pt_valid_d;
  logic [11:0] pt_x_q, pt_x_d;
  logic [11:0] pt_y_q, pt_y_d;
  logic        pt_laser_q, pt_laser_d;
  logic        pt_last_q, pt_last_d;
  logic [15:0] fc_q, fc_d;
  logic        poll_due;
  logic        din_id_new;
  logic        list_id_new;
  logic        unused_din_bits;

  point_fetch_poll_timer #(
    .POLL_CYCLES(POLL_CYCLES)
  ) u_poll_timer (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .en_i     (state_q == S_IDLE),
    .expired_o(poll_due)
  );

  // Bits [30:25] of the status/point words carry nothing for this block.
  assign unused_din_bits = ^mem_din[30:25];

  // An id needs acknowledging if nothing was acked since reset or it differs.
  assign din_id_new  = !acked_valid_q || (mem_din[ID_MSB:ID_LSB] != acked_id_q);
  assign list_id_new = !acked_valid_q || (id_q != acked_id_q);

  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    n_d           = n_q;
    idx_d         = idx_q;
    acked_id_d    = acked_id_q;
    acked_valid_d = acked_valid_q;
    pt_valid_d    = pt_valid_q;
    pt_x_d        = pt_x_q;
    pt_y_d        = pt_y_q;
    pt_laser_d    = pt_laser_q;
    pt_last_d     = pt_last_q;
    fc_d          = fc_q;
    mem_addr      = '0;
    mem_dout      = '0;
    mem_we        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (poll_due) state_d = S_POLL;
      end
      S_POLL: begin
        mem_addr = HOST_STAT_ADDR;
        state_d  = S_POLL_WAIT;
      end
      S_POLL_WAIT: begin
        // id and count stay frozen from here until the next poll.
        id_d  = mem_din[ID_MSB:ID_LSB];
        n_d   = mem_din[N_MSB:N_LSB];
        idx_d = '0;
        if (!mem_din[GO_BIT]) begin
          state_d = S_IDLE;
        end else if (mem_din[N_MSB:N_LSB] == 8'd0) begin
          // Empty list: ack a new id once, then rest in IDLE rather than
          // re-polling back to back.
          state_d = din_id_new ? S_ACK : S_IDLE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        mem_addr = point_addr(idx_q);
        state_d  = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        pt_x_d     = mem_din[X_MSB:X_LSB];
        pt_y_d     = mem_din[Y_MSB:Y_LSB];
        pt_laser_d = mem_din[LASER_BIT];
        pt_last_d  = (idx_q == n_q - 8'd1);
        pt_valid_d = 1'b1;
        state_d    = S_OUT;
      end
      S_OUT: begin
        if (pt_ready) begin
          pt_valid_d = 1'b0;
          if (pt_last_q) begin
            fc_d    = fc_q + 16'd1;
            // Straight back to POLL so a new frame takes over at the list end.
            state_d = list_id_new ? S_ACK : S_POLL;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = S_FETCH;
          end
        end
      end
      S_ACK: begin
        mem_addr      = CLIENT_STAT_ADDR;
        mem_dout      = ack_word(id_q, n_q);
        mem_we        = 1'b1;
        acked_id_d    = id_q;
        acked_valid_d = 1'b1;
        state_d       = (n_q == 8'd0) ? S_IDLE : S_POLL;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      id_q          <= '0;
      n_q           <= '0;
      idx_q         <= '0;
      acked_id_q    <= '0;
      acked_valid_q <= 1'b0;
      pt_valid_q    <= 1'b0;
      pt_x_q        <= '0;
      pt_y_q        <= '0;
      pt_laser_q    <= 1'b0;
      pt_last_q     <= 1'b0;
      fc_q          <= '0;
    end else begin
      state_q       <= state_d;
      id_q          <= id_d;
      n_q           <= n_d;
      idx_q         <= idx_d;
      acked_id_q    <= acked_id_d;
      acked_valid_q <= acked_valid_d;
      pt_valid_q    <= pt_valid_d;
      pt_x_q        <= pt_x_d;
      pt_y_q        <= pt_y_d;
      pt_laser_q    <= pt_laser_d;
      pt_last_q     <= pt_last_d;
      fc_q          <= fc_d;
    end
  end

  assign pt_valid    = pt_valid_q;
  assign pt_x        = pt_x_q;
  assign pt_y        = pt_y_q;
  assign pt_laser    = pt_laser_q;
  assign pt_last     = pt_last_q;
  assign busy        = (state_q != S_IDLE);
  assign frame_count = fc_q;

endmodule

// File: tb/tb_point_fetch.sv
// tb_point_fetch: self-checking bench for point_fetch with a shared-memory
// model, a point/ack scoreboard and a table of list scenarios.
module tb_point_fetch;

  localparam int PC = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        mem_we;
  logic        pt_valid;
  logic        pt_ready;
  logic [11:0] pt_x;
  logic [11:0] pt_y;
  logic        pt_laser;
  logic        pt_last;
  logic        busy;
  logic [15:0] frame_count;

  point_fetch #(.POLL_CYCLES(PC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout),
    .mem_we     (mem_we),
    .pt_valid   (pt_valid),
    .pt_ready   (pt_ready),
    .pt_x       (pt_x),
    .pt_y       (pt_y),
    .pt_laser   (pt_laser),
    .pt_last    (pt_last),
    .busy       (busy),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // Shared memory: registered read, one cycle after the address.
  logic [31:0] ram [256];
  logic [31:0] host_w;
  always @(posedge clk) begin
    if (mem_addr == 32'h400) mem_din <= host_w;
    else                     mem_din <= ram[mem_addr[9:2]];
  end

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    logic        laser;
    logic        last;
    bit          chk_gap;
  } pt_t;

  typedef struct {
    logic [7:0] id;
    logic [7:0] n;
    int         set;
    int         passes;
    bit         exp_ack;
  } scen_t;

  pt_t         exp_q[$];
  logic [31:0] ack_q[$];
  logic [24:0] pts [3][3];
  scen_t       tbl [6];

  int     n_cmp = 0;
  int     n_err = 0;
  int     hs_count = 0;
  int     ack_count = 0;
  int     fc_model = 0;
  longint cyc = 0;
  longint last_hs_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Monitor: handshakes, stall stability and ack writes, sampled mid-cycle.
  logic        stall_prev = 1'b0;
  logic [25:0] held;
  pt_t         e_mon;
  always @(negedge clk) begin
    if (!reset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        chk("hold_stable", {5'b0, pt_valid, pt_last, pt_laser, pt_y, pt_x}, {5'b0, 1'b1, held});
      if (pt_valid && pt_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_point: got x=%h y=%h, expected no point", pt_x, pt_y);
        end else begin
          e_mon = exp_q.pop_front();
          chk("point", {5'b0, 1'b1, pt_last, pt_laser, pt_y, pt_x},
              {5'b0, 1'b1, e_mon.last, e_mon.laser, e_mon.y, e_mon.x});
          if (e_mon.chk_gap) chk("point_gap", 32'(cyc - last_hs_cyc), 32'd3);
        end
        last_hs_cyc = cyc;
      end
      stall_prev = pt_valid && !pt_ready;
      held       = {pt_last, pt_laser, pt_y, pt_x};
      if (mem_we) begin
        ack_count++;
        chk("ack_addr", mem_addr, 32'h404);
        if (ack_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_ack: got %h, expected no write", mem_dout);
        end else begin
          chk("ack_word", mem_dout, ack_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ram(input int s);
    for (int i = 0; i < 3; i++) ram[i] = {7'h55, pts[s][i]};
  endtask

  task automatic push_pass(input int s, input int n, input int cnt, input bit gap);
    pt_t e;
    for (int i = 0; i < cnt; i++) begin
      e.x       = pts[s][i][11:0];
      e.y       = pts[s][i][23:12];
      e.laser   = pts[s][i][24];
      e.last    = (i == n - 1);
      e.chk_gap = gap && (i > 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_hs(input int target, input string name);
    int budget = 300;
    while (hs_count < target && budget > 0) begin
      tick();
      budget--;
    end
    if (hs_count < target) timeout_fail(name);
  endtask

  task automatic wait_idle(input string name);
    int budget = 100;
    while (busy && budget > 0) begin
      tick();
      budget--;
    end
    if (busy) timeout_fail(name);
  endtask

  task automatic wait_valid(input string name);
    int budget = 50;
    while (!pt_valid && budget > 0) begin
      tick();
      budget--;
    end
    if (!pt_valid) timeout_fail(name);
  endtask

  task automatic wait_first_poll(input string name);
    int n = 0;
    while (!busy && n < PC + 10) begin
      tick();
      n++;
    end
    chk({name, "_cycle"}, n, PC);
    chk({name, "_addr"}, mem_addr, 32'h400);
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_dout"}, mem_dout, 32'h0);
    chk({tag, "_flags"}, {27'b0, mem_we, pt_valid, pt_laser, pt_last, busy}, 32'h0);
    chk({tag, "_pt_xy"}, {8'b0, pt_y, pt_x}, 32'h0);
    chk({tag, "_frame_count"}, {16'b0, frame_count}, 32'h0);
  endtask

  task automatic check_drained(input string tag);
    chk({tag, "_pts_left"}, exp_q.size(), 0);
    chk({tag, "_acks_left"}, ack_q.size(), 0);
    chk({tag, "_frame_count"}, {16'b0, frame_count}, fc_model);
    exp_q.delete();
    ack_q.delete();
  endtask

  task automatic run_row(input scen_t r, input string tag);
    int base     = hs_count;
    int base_ack = ack_count;
    int nn       = int'(r.n);
    int budget;
    bit saw_valid;
    if (r.exp_ack) ack_q.push_back({1'b1, 15'b0, r.id, r.n});
    if (nn == 0) begin
      host_w   = {1'b1, 15'b0, r.id, r.n};
      pt_ready = 1'b1;
      budget   = 3 * PC;
      while (ack_count == base_ack && budget > 0) begin
        tick();
        budget--;
      end
      if (ack_count == base_ack) timeout_fail({tag, "_ack"});
      chk({tag, "_back_to_idle"}, {31'b0, busy}, 32'h0);
      // Further polls of the same empty list must neither ack nor emit.
      saw_valid = 1'b0;
      for (int i = 0; i < 3 * PC; i++) begin
        tick();
        saw_valid |= pt_valid;
      end
      chk({tag, "_no_valid"}, {31'b0, saw_valid}, 32'h0);
      chk({tag, "_no_points"}, hs_count - base, 0);
      host_w[31] = 1'b0;
      pt_ready   = 1'b0;
      wait_idle({tag, "_idle"});
    end else begin
      load_ram(r.set);
      for (int p = 0; p < r.passes; p++) push_pass(r.set, nn, nn, 1'b1);
      host_w   = {1'b1, 15'b0, r.id, r.n};
      pt_ready = 1'b1;
      wait_hs(base + (r.passes - 1) * nn + 1, {tag, "_last_pass"});
      host_w[31] = 1'b0;
      wait_hs(base + r.passes * nn, {tag, "_list_end"});
      pt_ready = 1'b0;
      wait_idle({tag, "_idle"});
      fc_model += r.passes;
    end
    check_drained(tag);
  endtask

  initial begin
    int base;
    // Point sets: {laser, y, x}
    pts[0][0] = {1'b1, 12'h020, 12'h010};
    pts[0][1] = {1'b0, 12'h000, 12'h7FF};
    pts[0][2] = {1'b1, 12'hFFF, 12'hFFF};
    pts[1][0] = {1'b0, 12'h456, 12'h123};
    pts[1][1] = {1'b1, 12'h001, 12'hABC};
    pts[1][2] = {1'b0, 12'h000, 12'h000};
    pts[2][0] = {1'b1, 12'h7FF, 12'h800};
    pts[2][1] = {1'b0, 12'hFFE, 12'h001};
    pts[2][2] = {1'b1, 12'hAAA, 12'h555};
    // Scenarios: id, N, point set, passes, ack expected
    tbl[0] = '{8'h05, 8'd3, 0, 3, 1'b1};
    tbl[1] = '{8'h05, 8'd3, 0, 1, 1'b0};
    tbl[2] = '{8'h06, 8'd0, 0, 0, 1'b1};
    tbl[3] = '{8'h05, 8'd2, 1, 1, 1'b1};
    tbl[4] = '{8'h05, 8'd2, 1, 2, 1'b0};
    tbl[5] = '{8'h12, 8'd3, 2, 1, 1'b1};

    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    host_w   = 32'h0;
    pt_ready = 1'b0;
    reset_n  = 1'b0;
    tick();
    tick();
    check_reset_outs("reset");
    reset_n = 1'b1;
    wait_first_poll("first_poll");
    wait_idle("go0_idle");

    for (int r = 0; r < 6; r++) run_row(tbl[r], $sformatf("row%0d", r));

    // Stall on point 2 for 10 cycles.
    base = hs_count;
    load_ram(0);
    push_pass(0, 3, 3, 1'b0);
    ack_q.push_back(32'h8000_0903);
    host_w   = {1'b1, 15'b0, 8'h09, 8'd3};
    pt_ready = 1'b1;
    wait_hs(base + 1, "stall_p1");
    pt_ready   = 1'b0;
    host_w[31] = 1'b0;
    wait_valid("stall_p2");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_valid", {31'b0, pt_valid}, 32'h1);
      chk("stall_no_fetch", mem_addr, 32'h0);
    end
    pt_ready = 1'b1;
    wait_hs(base + 3, "stall_end");
    pt_ready = 1'b0;
    wait_idle("stall_idle");
    fc_model += 1;
    check_drained("stall");

    // Host switches to id 0x07, N=2 while the 0x0A list is in flight.
    base = hs_count;
    load_ram(0);
    push_pass(0, 3, 3, 1'b1);
    ack_q.push_back(32'h8000_0A03);
    push_pass(0, 2, 2, 1'b1);
    ack_q.push_back(32'h8000_0702);
    host_w   = {1'b1, 15'b0, 8'h0A, 8'd3};
    pt_ready = 1'b1;
    wait_hs(base + 1, "mid_first");
    host_w = {1'b1, 15'b0, 8'h07, 8'd2};
    wait_hs(base + 4, "mid_new_first");
    host_w[31] = 1'b0;
    wait_hs(base + 5, "mid_new_end");
    pt_ready = 1'b0;
    wait_idle("mid_idle");
    fc_model += 2;
    check_drained("midlist");

    // Reset while point 2 of the second pass of an acked id is in OUT.
    base = hs_count;
    push_pass(0, 3, 3, 1'b1);
    push_pass(0, 3, 1, 1'b0);
    ack_q.push_back(32'h8000_0B03);
    host_w   = {1'b1, 15'b0, 8'h0B, 8'd3};
    pt_ready = 1'b1;
    wait_hs(base + 4, "rst_pass2_p1");
    pt_ready = 1'b0;
    wait_valid("rst_stall");
    reset_n = 1'b0;
    tick();
    check_reset_outs("midreset");
    chk("midreset_pts_left", exp_q.size(), 0);
    chk("midreset_acks_left", ack_q.size(), 0);
    exp_q.delete();
    ack_q.delete();
    tick();
    reset_n  = 1'b1;
    fc_model = 0;
    push_pass(0, 3, 3, 1'b1);
    ack_q.push_back(32'h8000_0B03);
    pt_ready = 1'b1;
    wait_first_poll("post_reset_poll");
    base = hs_count;
    wait_hs(base + 1, "post_reset_p1");
    host_w[31] = 1'b0;
    wait_hs(base + 3, "post_reset_end");
    pt_ready = 1'b0;
    wait_idle("post_reset_idle");
    fc_model = 1;
    check_drained("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
